// File: rtl/clock_mode_ctrl_if.sv
// Bundle of buttons, ticks, current time and the controller's outputs for clock_mode_ctrl.
interface clock_mode_ctrl_if;
    logic       i_tick_1hz;
    logic       i_tick_100hz;
    logic       i_sw0;
    logic       i_sw1;
    logic       i_sw2;
    logic [4:0] i_hour;
    logic [5:0] i_min;
    logic [5:0] i_sec;
    logic [1:0] o_mode;
    logic [1:0] o_position;
    logic [2:0] o_inc;
    logic       o_carry_en;
    logic [5:0] o_blink_mask;
    logic [4:0] o_alm_hour;
    logic [5:0] o_alm_min;
    logic       o_alm_en;
    logic       o_alarm;

    // Driver side: buttons, ticks and current time in, controller outputs back.
    modport master (
        output i_tick_1hz, i_tick_100hz, i_sw0, i_sw1, i_sw2, i_hour, i_min, i_sec,
        input  o_mode, o_position, o_inc, o_carry_en, o_blink_mask, o_alm_hour, o_alm_min,
               o_alm_en, o_alarm
    );

    // Controller side.
    modport slave (
        input  i_tick_1hz, i_tick_100hz, i_sw0, i_sw1, i_sw2, i_hour, i_min, i_sec,
        output o_mode, o_position, o_inc, o_carry_en, o_blink_mask, o_alm_hour, o_alm_min,
               o_alm_en, o_alarm
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Mode/setup sequencer for the H:M:S clock: button edges, auto-repeat, blink masks and alarm.
module clock_mode_ctrl #(
    parameter int unsigned HOLD_DLY    = 50,
    parameter int unsigned RPT_PERIOD  = 10,
    parameter int unsigned BLINK_HALF  = 50,
    parameter int unsigned ALM_TIMEOUT = 30
) (
    input logic              clk,
    input logic              rst_n,
    clock_mode_ctrl_if.slave bus
);
    // Wide enough for any of the tick counters.
    localparam int unsigned CntW = $clog2(HOLD_DLY + RPT_PERIOD + BLINK_HALF + ALM_TIMEOUT + 1);

    typedef enum logic [1:0] {StClock = 2'd0, StSetup = 2'd1, StAlarm = 2'd2} mode_e;
    typedef enum logic [1:0] {PosSec = 2'd0, PosMin = 2'd1, PosHour = 2'd2} pos_e;

    mode_e mode_q, mode_d;
    pos_e  pos_q, pos_d;

    logic sw0_q, sw1_q, sw2_q;
    logic rise0, rise1, rise2, any_rise;
    logic act0, act1, act2;
    logic pos_change, setup_like, inc_event;

    logic            rpt_on_q, rpt_on_d;
    logic            rpt_phase_q, rpt_phase_d;
    logic [CntW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            rpt_event;

    logic            blink_q, blink_d;
    logic [CntW-1:0] blink_cnt_q, blink_cnt_d;

    logic [2:0]      inc_q, inc_d;
    logic [4:0]      alm_hour_q, alm_hour_d;
    logic [5:0]      alm_min_q, alm_min_d;
    logic            alm_en_q, alm_en_d;
    logic            alarm_q, alarm_d;
    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            raise, tmo_done;
    logic [5:0]      mask;

    // While ringing, any rise only clears the alarm; sw0 pre-empts sw1/sw2.
    assign rise0      = bus.i_sw0 & ~sw0_q;
    assign rise1      = bus.i_sw1 & ~sw1_q;
    assign rise2      = bus.i_sw2 & ~sw2_q;
    assign any_rise   = rise0 | rise1 | rise2;
    assign act0       = rise0 & ~alarm_q;
    assign act1       = rise1 & ~alarm_q & ~rise0;
    assign act2       = rise2 & ~alarm_q & ~rise0;
    assign setup_like = (mode_q != StClock);

    // Mode/position state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= StClock;
            pos_q  <= PosSec;
        end else begin
            mode_q <= mode_d;
            pos_q  <= pos_d;
        end
    end

    // Mode/position next state from sw0 and sw1 rises.
    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        if (act0) begin
            unique case (mode_q)
                StClock: begin mode_d = StSetup; pos_d = PosSec; end
                StSetup: begin mode_d = StAlarm; pos_d = PosMin; end
                default: begin mode_d = StClock; pos_d = PosSec; end
            endcase
        end else if (act1) begin
            if (mode_q == StSetup) begin
                unique case (pos_q)
                    PosSec:  pos_d = PosMin;
                    PosMin:  pos_d = PosHour;
                    default: pos_d = PosSec;
                endcase
            end else if (mode_q == StAlarm) begin
                pos_d = (pos_q == PosHour) ? PosMin : PosHour;
            end
        end
    end

    assign pos_change = (mode_d != mode_q) || (pos_d != pos_q);

    // Auto-repeat: hold phase of HOLD_DLY ticks, then one event every RPT_PERIOD ticks.
    always_comb begin
        rpt_on_d    = rpt_on_q;
        rpt_phase_d = rpt_phase_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_event   = 1'b0;
        if (pos_change || !bus.i_sw2 || alarm_q) begin
            rpt_on_d    = 1'b0;
            rpt_phase_d = 1'b0;
            rpt_cnt_d   = '0;
        end else if (act2 && setup_like) begin
            rpt_on_d    = 1'b1;
            rpt_phase_d = 1'b0;
            rpt_cnt_d   = '0;
        end else if (rpt_on_q && bus.i_tick_100hz) begin
            if (!rpt_phase_q && rpt_cnt_q == CntW'(HOLD_DLY - 1)) begin
                rpt_event   = 1'b1;
                rpt_phase_d = 1'b1;
                rpt_cnt_d   = '0;
            end else if (rpt_phase_q && rpt_cnt_q == CntW'(RPT_PERIOD - 1)) begin
                rpt_event = 1'b1;
                rpt_cnt_d = '0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + CntW'(1);
            end
        end
    end

    assign inc_event = setup_like & ((act2 & ~pos_change) | rpt_event);

    // Increment pulses, alarm register edits, arming, blink phase and alarm ringing.
    always_comb begin
        inc_d       = 3'b000;
        alm_hour_d  = alm_hour_q;
        alm_min_d   = alm_min_q;
        alm_en_d    = alm_en_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;

        if (mode_q == StSetup) begin
            if (inc_event) begin
                unique case (pos_q)
                    PosSec:  inc_d = 3'b001;
                    PosMin:  inc_d = 3'b010;
                    default: inc_d = 3'b100;
                endcase
            end
        end else begin
            inc_d = {2'b00, bus.i_tick_1hz};
        end

        if (mode_q == StAlarm && inc_event) begin
            if (pos_q == PosHour) begin
                alm_hour_d = (alm_hour_q == 5'd23) ? 5'd0 : alm_hour_q + 5'd1;
            end else begin
                alm_min_d = (alm_min_q == 6'd59) ? 6'd0 : alm_min_q + 6'd1;
            end
        end

        if (mode_q == StClock && act2) begin
            alm_en_d = ~alm_en_q;
        end

        if (pos_change) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (bus.i_tick_100hz) begin
            if (blink_cnt_q == CntW'(BLINK_HALF - 1)) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + CntW'(1);
            end
        end

        raise = alm_en_q & bus.i_tick_1hz & ~alarm_q & (mode_q != StSetup) &
                (bus.i_hour == alm_hour_q) & (bus.i_min == alm_min_q) & (bus.i_sec == 6'd0);
        tmo_done = alarm_q & bus.i_tick_1hz & (tmo_cnt_q == CntW'(ALM_TIMEOUT - 1));
        // Clear wins over raise in the same cycle.
        alarm_d = (alarm_q | raise) & ~(any_rise | tmo_done);
        if (!alarm_q) begin
            tmo_cnt_d = '0;
        end else if (bus.i_tick_1hz) begin
            tmo_cnt_d = tmo_cnt_q + CntW'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw0_q       <= 1'b0;
            sw1_q       <= 1'b0;
            sw2_q       <= 1'b0;
            rpt_on_q    <= 1'b0;
            rpt_phase_q <= 1'b0;
            rpt_cnt_q   <= '0;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
            inc_q       <= 3'b000;
            alm_hour_q  <= 5'd0;
            alm_min_q   <= 6'd0;
            alm_en_q    <= 1'b0;
            alarm_q     <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            sw0_q       <= bus.i_sw0;
            sw1_q       <= bus.i_sw1;
            sw2_q       <= bus.i_sw2;
            rpt_on_q    <= rpt_on_d;
            rpt_phase_q <= rpt_phase_d;
            rpt_cnt_q   <= rpt_cnt_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            inc_q       <= inc_d;
            alm_hour_q  <= alm_hour_d;
            alm_min_q   <= alm_min_d;
            alm_en_q    <= alm_en_d;
            alarm_q     <= alarm_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // Blink mask: only the selected field follows the blink phase outside CLOCK.
    always_comb begin
        mask = 6'h3F;
        if (setup_like) begin
            case (pos_q)
                PosSec:  mask[1:0] = {2{blink_q}};
                PosMin:  mask[3:2] = {2{blink_q}};
                PosHour: mask[5:4] = {2{blink_q}};
                default: mask = 6'h3F;
            endcase
        end
    end

    assign bus.o_mode       = mode_q;
    assign bus.o_position   = pos_q;
    assign bus.o_inc        = inc_q;
    assign bus.o_carry_en   = (mode_q != StSetup);
    assign bus.o_blink_mask = mask;
    assign bus.o_alm_hour   = alm_hour_q;
    assign bus.o_alm_min    = alm_min_q;
    assign bus.o_alm_en     = alm_en_q;
    assign bus.o_alarm      = alarm_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: o_inc pulses go through a cycle-stamped scoreboard.
module tb_clock_mode_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    typedef struct {
        logic [2:0] inc;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    clock_mode_ctrl_if bus ();

    clock_mode_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every nonzero o_inc must match the oldest expected pulse, including its cycle.
    always @(negedge clk) begin
        if (rst_n && bus.o_inc !== 3'b000) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL inc_unexpected: got %b at cycle %0d, required none", bus.o_inc, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.o_inc !== e.inc || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL inc_pulse: got %b at cycle %0d, required %b at cycle %0d",
                             bus.o_inc, cyc, e.inc, e.cyc);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_exp(input logic [2:0] inc);
        exp_t e;
        e.inc = inc;
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic press(input int sw, input logic [2:0] exp_inc);
        @(negedge clk);
        if (sw == 0) bus.i_sw0 = 1'b1;
        if (sw == 1) bus.i_sw1 = 1'b1;
        if (sw == 2) bus.i_sw2 = 1'b1;
        if (exp_inc != 3'b000) push_exp(exp_inc);
        @(negedge clk);
        bus.i_sw0 = 1'b0;
        bus.i_sw1 = 1'b0;
        bus.i_sw2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick1(input logic [2:0] exp_inc);
        @(negedge clk);
        bus.i_tick_1hz = 1'b1;
        if (exp_inc != 3'b000) push_exp(exp_inc);
        @(negedge clk);
        bus.i_tick_1hz = 1'b0;
    endtask

    task automatic tick100(input logic [2:0] exp_inc);
        @(negedge clk);
        bus.i_tick_100hz = 1'b1;
        if (exp_inc != 3'b000) push_exp(exp_inc);
        @(negedge clk);
        bus.i_tick_100hz = 1'b0;
    endtask

    task automatic check_sb_empty(input string name);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected o_inc pulses never seen, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        bus.i_tick_1hz = 1'b0; bus.i_tick_100hz = 1'b0;
        bus.i_sw0 = 1'b0; bus.i_sw1 = 1'b0; bus.i_sw2 = 1'b0;
        bus.i_hour = 5'd0; bus.i_min = 6'd0; bus.i_sec = 6'd1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_mode !== 2'd0 || bus.o_position !== 2'd0 || bus.o_inc !== 3'b000) begin
            errors++;
            $display("FAIL reset_mode: mode %0d pos %0d inc %b, required 0 0 000",
                     bus.o_mode, bus.o_position, bus.o_inc);
        end
        checks++;
        if (bus.o_carry_en !== 1'b1 || bus.o_blink_mask !== 6'h3F) begin
            errors++;
            $display("FAIL reset_mask: carry %b mask %h, required 1 3f",
                     bus.o_carry_en, bus.o_blink_mask);
        end
        checks++;
        if (bus.o_alm_hour !== 5'd0 || bus.o_alm_min !== 6'd0 || bus.o_alm_en !== 1'b0 ||
            bus.o_alarm !== 1'b0) begin
            errors++;
            $display("FAIL reset_alarm: hour %0d min %0d en %b ring %b, required 0 0 0 0",
                     bus.o_alm_hour, bus.o_alm_min, bus.o_alm_en, bus.o_alarm);
        end
    endtask

    task automatic test_clock_ticks();
        repeat (3) tick1(3'b001);
        checks++;
        if (bus.o_carry_en !== 1'b1) begin
            errors++;
            $display("FAIL clock_carry: got %b, required 1", bus.o_carry_en);
        end
        check_sb_empty("clock_ticks");
    endtask

    task automatic test_setup();
        press(0, 3'b000);
        checks++;
        if (bus.o_mode !== 2'd1 || bus.o_position !== 2'd0 || bus.o_carry_en !== 1'b0) begin
            errors++;
            $display("FAIL setup_enter: mode %0d pos %0d carry %b, required 1 0 0",
                     bus.o_mode, bus.o_position, bus.o_carry_en);
        end
        press(1, 3'b000);
        checks++;
        if (bus.o_position !== 2'd1 || bus.o_blink_mask !== 6'h3F) begin
            errors++;
            $display("FAIL setup_pos_min: pos %0d mask %h, required 1 3f",
                     bus.o_position, bus.o_blink_mask);
        end
        press(2, 3'b010);
        tick1(3'b000);
        tick1(3'b000);
        repeat (50) tick100(3'b000);
        checks++;
        if (bus.o_blink_mask !== 6'h33) begin
            errors++;
            $display("FAIL setup_blink: mask %h, required 33", bus.o_blink_mask);
        end
        press(1, 3'b000);
        checks++;
        if (bus.o_position !== 2'd2 || bus.o_blink_mask !== 6'h3F) begin
            errors++;
            $display("FAIL setup_pos_hour: pos %0d mask %h, required 2 3f",
                     bus.o_position, bus.o_blink_mask);
        end
        check_sb_empty("setup_inc");
    endtask

    task automatic test_repeat();
        @(negedge clk);
        bus.i_sw2 = 1'b1;
        push_exp(3'b100);
        for (int k = 1; k <= 110; k++) begin
            tick100((k >= 50 && k % 10 == 0) ? 3'b100 : 3'b000);
        end
        @(negedge clk);
        bus.i_sw2 = 1'b0;
        repeat (12) tick100(3'b000);
        check_sb_empty("repeat");
    endtask

    task automatic test_alarm_setting();
        press(0, 3'b000);
        checks++;
        if (bus.o_mode !== 2'd2 || bus.o_position !== 2'd1 || bus.o_carry_en !== 1'b1) begin
            errors++;
            $display("FAIL alarm_enter: mode %0d pos %0d carry %b, required 2 1 1",
                     bus.o_mode, bus.o_position, bus.o_carry_en);
        end
        tick1(3'b001);
        press(1, 3'b000);
        repeat (23) press(2, 3'b000);
        checks++;
        if (bus.o_alm_hour !== 5'd23) begin
            errors++;
            $display("FAIL alarm_hour_23: got %0d, required 23", bus.o_alm_hour);
        end
        press(2, 3'b000);
        checks++;
        if (bus.o_alm_hour !== 5'd0) begin
            errors++;
            $display("FAIL alarm_hour_wrap: got %0d, required 0", bus.o_alm_hour);
        end
        press(1, 3'b000);
        repeat (59) press(2, 3'b000);
        checks++;
        if (bus.o_alm_min !== 6'd59 || bus.o_position !== 2'd1) begin
            errors++;
            $display("FAIL alarm_min_59: min %0d pos %0d, required 59 1",
                     bus.o_alm_min, bus.o_position);
        end
        press(2, 3'b000);
        checks++;
        if (bus.o_alm_min !== 6'd0) begin
            errors++;
            $display("FAIL alarm_min_wrap: got %0d, required 0", bus.o_alm_min);
        end
        repeat (30) press(2, 3'b000);
        press(1, 3'b000);
        repeat (7) press(2, 3'b000);
        press(0, 3'b000);
        checks++;
        if (bus.o_alm_hour !== 5'd7 || bus.o_alm_min !== 6'd30 || bus.o_alm_en !== 1'b0 ||
            bus.o_mode !== 2'd0 || bus.o_position !== 2'd0) begin
            errors++;
            $display("FAIL alarm_set: %0d:%0d en %b mode %0d pos %0d, required 7:30 0 0 0",
                     bus.o_alm_hour, bus.o_alm_min, bus.o_alm_en, bus.o_mode, bus.o_position);
        end
        check_sb_empty("alarm_setting");
    endtask

    task automatic test_alarm_timeout();
        press(2, 3'b000);
        checks++;
        if (bus.o_alm_en !== 1'b1) begin
            errors++;
            $display("FAIL alarm_arm: got %b, required 1", bus.o_alm_en);
        end
        bus.i_hour = 5'd7; bus.i_min = 6'd30; bus.i_sec = 6'd5;
        tick1(3'b001);
        checks++;
        if (bus.o_alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_wrong_sec: got %b, required 0", bus.o_alarm);
        end
        bus.i_sec = 6'd0;
        tick1(3'b001);
        checks++;
        if (bus.o_alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_raise: got %b, required 1", bus.o_alarm);
        end
        bus.i_sec = 6'd1;
        repeat (29) tick1(3'b001);
        checks++;
        if (bus.o_alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_tmo_29: got %b, required 1", bus.o_alarm);
        end
        tick1(3'b001);
        checks++;
        if (bus.o_alarm !== 1'b0 || bus.o_alm_en !== 1'b1) begin
            errors++;
            $display("FAIL alarm_tmo_30: ring %b en %b, required 0 1", bus.o_alarm, bus.o_alm_en);
        end
        check_sb_empty("alarm_timeout");
    endtask

    task automatic test_alarm_press_clear();
        bus.i_sec = 6'd0;
        tick1(3'b001);
        bus.i_sec = 6'd1;
        press(2, 3'b000);
        checks++;
        if (bus.o_alarm !== 1'b0 || bus.o_alm_en !== 1'b1) begin
            errors++;
            $display("FAIL alarm_sw2_clear: ring %b en %b, required 0 1",
                     bus.o_alarm, bus.o_alm_en);
        end
        bus.i_sec = 6'd0;
        tick1(3'b001);
        bus.i_sec = 6'd1;
        checks++;
        if (bus.o_alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_reraise: got %b, required 1", bus.o_alarm);
        end
        press(0, 3'b000);
        checks++;
        if (bus.o_alarm !== 1'b0 || bus.o_mode !== 2'd0) begin
            errors++;
            $display("FAIL alarm_sw0_clear: ring %b mode %0d, required 0 0",
                     bus.o_alarm, bus.o_mode);
        end
        check_sb_empty("alarm_press_clear");
    endtask

    task automatic test_reset_mid();
        press(0, 3'b000);
        @(negedge clk);
        bus.i_sw2 = 1'b1;
        push_exp(3'b001);
        for (int k = 1; k <= 55; k++) begin
            tick100((k == 50) ? 3'b001 : 3'b000);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_mode !== 2'd0 || bus.o_position !== 2'd0 || bus.o_inc !== 3'b000 ||
            bus.o_carry_en !== 1'b1 || bus.o_blink_mask !== 6'h3F) begin
            errors++;
            $display("FAIL midreset_mode: mode %0d pos %0d inc %b carry %b mask %h",
                     bus.o_mode, bus.o_position, bus.o_inc, bus.o_carry_en, bus.o_blink_mask);
        end
        checks++;
        if (bus.o_alm_hour !== 5'd0 || bus.o_alm_min !== 6'd0 || bus.o_alm_en !== 1'b0 ||
            bus.o_alarm !== 1'b0) begin
            errors++;
            $display("FAIL midreset_alarm: hour %0d min %0d en %b ring %b, required 0 0 0 0",
                     bus.o_alm_hour, bus.o_alm_min, bus.o_alm_en, bus.o_alarm);
        end
        bus.i_sw2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick1(3'b001);
        check_sb_empty("reset_mid");
    endtask

    initial begin
        test_reset();
        test_clock_ticks();
        test_setup();
        test_repeat();
        test_alarm_setting();
        test_alarm_timeout();
        test_alarm_press_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
